// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub scheduler.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/addsub_sched_if.sv
// Request/response bundle between client engines and the add/sub scheduler.
interface addsub_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_add_sub;
    logic [NREQ*WIDTH-1:0] req_dataa;
    logic [NREQ*WIDTH-1:0] req_datab;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_result;
    logic                  resp_cb;

    modport master (
        output req_valid, req_add_sub, req_dataa, req_datab, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_cb
    );

    modport slave (
        input  req_valid, req_add_sub, req_dataa, req_datab, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_cb
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    // Prefer requesters at index >= ptr; wrap to the full vector when none.
    always_comb begin
        hi_mask = ~((N'(1) << ptr) - N'(1));
        masked  = req & hi_mask;
        pick    = (|masked) ? masked : req;
        gnt     = en ? (pick & (~pick + N'(1))) : '0;
    end

endmodule

// File: rtl/addsub_sched.sv
// Shares one registered add/sub datapath between NREQ requesters, one op in flight.
//
// state | meaning
// IDLE  | nothing in flight, ready to grant
// EXEC  | operands captured, result registered at end of this cycle
// RESP  | result presented, waiting for resp_ready
module addsub_sched
    import addsub_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    addsub_sched_if.slave   bus,
    output logic            busy
);
    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   id_q;
    logic [NREQ-1:0]  gnt;
    logic             accept;
    logic             hs;
    logic             op_sel, op_q;
    logic [WIDTH-1:0] a_sel, b_sel, a_q, b_q;
    logic [WIDTH:0]   sum;
    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [WIDTH-1:0] resp_result_q;
    logic             resp_cb_q;

    // Grants are only offered outside reset and while the response slot frees up.
    assign accept = !rst && ((state_q == IDLE) || ((state_q == RESP) && bus.resp_ready));

    rr_arbiter #(.N(NREQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .en  (accept),
        .gnt (gnt)
    );

    assign bus.req_ready   = gnt;
    assign hs              = |gnt;
    assign busy            = (state_q != IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_cb     = resp_cb_q;

    // Mux the granted requester's payload and index.
    always_comb begin
        gnt_id = '0;
        op_sel = 1'b0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
                op_sel = bus.req_add_sub[i];
                a_sel  = bus.req_dataa[i*WIDTH +: WIDTH];
                b_sel  = bus.req_datab[i*WIDTH +: WIDTH];
            end
        end
    end

    // WIDTH+1 bit arithmetic: top bit is carry for add, borrow for subtract.
    always_comb begin
        if (op_q == OP_ADD) sum = {1'b0, a_q} + {1'b0, b_q};
        else                sum = {1'b0, a_q} - {1'b0, b_q};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = hs ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            op_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_cb_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                op_q   <= op_sel;
                a_q    <= a_sel;
                b_q    <= b_sel;
                id_q   <= gnt_id;
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state_q == EXEC) begin
                resp_valid_q  <= 1'b1;
                resp_id_q     <= id_q;
                resp_result_q <= sum[WIDTH-1:0];
                resp_cb_q     <= sum[WIDTH];
            end else if ((state_q == RESP) && bus.resp_ready) begin
                resp_valid_q  <= 1'b0;
            end
        end
    end

endmodule
